countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  Loadable BCD minutes:seconds countdown timer (max 9:59), the down-counting counterpart of the stopwatch.
//  Counts down one second per prescaled tick, pauses/resumes on command, flags expiry at 0:00.
//  Digit outputs use the same BCD encoding as the stopwatch so the same display path can drive either.
// PARAMETERS
//  TICK_DIV  1  clk cycles per one-second tick (>=1); prescaler width = ceil(log2(TICK_DIV)), min 1
// PORTS
//  clk       in   1  single clock, all state updates on rising edge
//  reset     in   1  asynchronous, active-low reset (0 = reset asserted)
//  load      in   1  load set_* digits into the counter (level, sampled each edge)
//  start     in   1  start/resume counting
//  stop      in   1  pause counting
//  set_ones  in   4  preset seconds units, BCD
//  set_tens  in   3  preset seconds tens, BCD
//  set_min   in   4  preset minutes, BCD
//  dout1     out  4  seconds units, 0-9
//  dout2     out  3  seconds tens, 0-5
//  dout3     out  4  minutes, 0-9
//  running   out  1  1 while in RUN
//  done      out  1  1 while in DONE (level)
//  expired   out  1  one-cycle pulse, high in the cycle the outputs first show 0:00
// BEHAVIOUR
//  Reset (reset=0, async): dout1/2/3=0, running=0, done=0, expired=0, prescaler=0, state IDLE.
//  States: IDLE, RUN, PAUSE, DONE. running/done are registered decodes of state.
//  Command priority per edge: load > stop > start.
//  load (any state): digits <= clamped set_*, prescaler <= 0, state <= IDLE, expired <= 0.
//   Clamp: set_ones>9 -> 9; set_tens>5 -> 5; set_min>9 -> 9. Load wins over a same-cycle tick.
//  start: IDLE/PAUSE -> RUN if count != 0:00; if count == 0:00 stay in current state, no expired.
//   start in RUN or DONE ignored.
//  stop: RUN -> PAUSE; ignored elsewhere. stop+start same cycle: stop wins (RUN->PAUSE, else no-op).
//  Prescaler: increments only in RUN; tick = (state==RUN && presc==TICK_DIV-1), presc wraps to 0.
//   Holds its value in PAUSE (resume completes the partial second); cleared on load and on expiry.
//  Latency: start sampled at edge N -> running=1 after N; first decrement at edge N+TICK_DIV.
//  Decrement on tick (BCD borrow chain):
//   ones>0: ones-1. ones==0: ones<=9; tens>0: tens-1; tens==0: tens<=5, min-1.
//   Never decrements below 0:00 (RUN is never entered at 0:00).
//  Expiry: tick that produces 0:00 -> state DONE, expired=1 for exactly that next cycle, running=0, done=1.
//  DONE: count holds 0:00; start/stop ignored; only load or reset leave DONE.
//  No digit ever leaves its legal BCD range (dout1<=9, dout2<=5, dout3<=9).
// TESTING
//  1. TICK_DIV=1, load 0:12, start -> 0:11,0:10,0:09..0:00 on consecutive edges; expired 1 cycle at 0:00, done=1.
//  2. TICK_DIV=1, load 1:00, start -> next tick shows 0:59 (dout3=0,dout2=5,dout1=9); later 0:50 -> 0:49.
//  3. TICK_DIV=4, load 0:05, start, stop 6 cycles after start -> holds 0:04 with presc=2; start -> 0:03 2 edges later.
//  4. load set_ones=12,set_tens=7,set_min=15 -> outputs 9:59, state IDLE; start with 0:00 loaded -> stays IDLE, expired never 1.
//  5. In DONE: start -> no change; load 0:03 -> IDLE, done=0, outputs 0:03; load+tick same cycle -> loaded value wins.
//  6. reset low mid-RUN between edges -> outputs 0 immediately (async); release -> IDLE, no count until start.

Source files
------------

// File: rtl/countdown_timer.sv
// ----------------------------------------------------------------------------
// countdown_timer
//
// Purpose:
//   Loadable BCD minutes:seconds countdown timer with a maximum of 9:59.
//   It counts down one second per prescaled tick. It can be paused and
//   resumed, and it flags expiry when the count reaches 0:00. The digit
//   encoding matches the stopwatch, so the same display path can drive
//   either block.
//
// Parameters:
//   TICK_DIV  clk cycles per one-second tick (>= 1)
//
// Ports:
//   clk       in   1  single clock, all state updates on the rising edge
//   reset     in   1  asynchronous, active-low reset (0 = reset asserted)
//   load      in   1  load the clamped set_* digits (level, sampled each edge)
//   start     in   1  start/resume counting
//   stop      in   1  pause counting
//   set_ones  in   4  preset seconds units, BCD
//   set_tens  in   3  preset seconds tens, BCD
//   set_min   in   4  preset minutes, BCD
//   dout1     out  4  seconds units, 0-9
//   dout2     out  3  seconds tens, 0-5
//   dout3     out  4  minutes, 0-9
//   running   out  1  high while counting (RUN)
//   done      out  1  high while expired and waiting for a load (DONE)
//   expired   out  1  one-cycle pulse in the first cycle showing 0:00
// ----------------------------------------------------------------------------
module countdown_timer #(
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] set_ones,
    input  logic [2:0] set_tens,
    input  logic [3:0] set_min,
    output logic [3:0] dout1,
    output logic [2:0] dout2,
    output logic [3:0] dout3,
    output logic       running,
    output logic       done,
    output logic       expired
);

    // The prescaler is at least one bit wide, so TICK_DIV=1 still builds.
    localparam int PW = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nx;
    logic [3:0]    ones_nx;
    logic [2:0]    tens_nx;
    logic [3:0]    min_nx;
    logic          expired_nx;
    logic          tick;
    logic          count_zero;

    // A tick marks the last cycle of the current one-second period.
    // With TICK_DIV=1, PRESC_MAX is 0, so every RUN cycle is a tick.
    assign tick       = (state == S_RUN) && (presc == PRESC_MAX);
    assign count_zero = (dout1 == 4'd0) && (dout2 == 3'd0) && (dout3 == 4'd0);

    // Next-state and next-count logic.
    // The command priority is load > stop > start. In RUN, the prescaler
    // advances even on the edge where stop is sampled. This lets a resume
    // finish the partial second that was interrupted. If expiry and stop
    // arrive together, expiry takes the timer to DONE, because a paused
    // 0:00 could never be resumed anyway.
    always_comb begin
        state_nx   = state;
        presc_nx   = presc;
        ones_nx    = dout1;
        tens_nx    = dout2;
        min_nx     = dout3;
        expired_nx = 1'b0;

        if (load) begin
            ones_nx  = (set_ones > 4'd9) ? 4'd9 : set_ones;
            tens_nx  = (set_tens > 3'd5) ? 3'd5 : set_tens;
            min_nx   = (set_min  > 4'd9) ? 4'd9 : set_min;
            presc_nx = '0;
            state_nx = S_IDLE;
        end else if (state == S_RUN) begin
            if (tick) begin
                presc_nx = '0;
                // BCD borrow chain: units, then tens, then minutes.
                if (dout1 != 4'd0) begin
                    ones_nx = dout1 - 4'd1;
                end else begin
                    ones_nx = 4'd9;
                    if (dout2 != 3'd0) begin
                        tens_nx = dout2 - 3'd1;
                    end else begin
                        tens_nx = 3'd5;
                        min_nx  = dout3 - 4'd1;
                    end
                end
                if ((ones_nx == 4'd0) && (tens_nx == 3'd0) && (min_nx == 4'd0)) begin
                    state_nx   = S_DONE;
                    expired_nx = 1'b1;
                end
            end else begin
                presc_nx = presc + PW'(1);
            end

            if (stop && (state_nx == S_RUN)) begin
                state_nx = S_PAUSE;
            end
        end else if ((state == S_IDLE) || (state == S_PAUSE)) begin
            // A zero count never enters RUN. This rule keeps the borrow
            // chain from ever wrapping below 0:00.
            if (start && !stop && !count_zero) begin
                state_nx = S_RUN;
            end
        end
    end

    // State, count and registered status flags.
    // running and done are decoded from the next state. They therefore
    // change on the same edge as the state itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            presc   <= '0;
            dout1   <= 4'd0;
            dout2   <= 3'd0;
            dout3   <= 4'd0;
            running <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_nx;
            presc   <= presc_nx;
            dout1   <= ones_nx;
            dout2   <= tens_nx;
            dout3   <= min_nx;
            running <= (state_nx == S_RUN);
            done    <= (state_nx == S_DONE);
            expired <= expired_nx;
        end
    end

    // Structural invariants of the count and the status flags.
    digit_ranges : assert property (@(posedge clk) disable iff (!reset)
        (dout1 <= 4'd9) && (dout2 <= 3'd5) && (dout3 <= 4'd9));

    flags_exclusive : assert property (@(posedge clk) disable iff (!reset)
        !(running && done));

    expired_in_done : assert property (@(posedge clk) disable iff (!reset)
        expired |-> (done && count_zero));

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic       start;
    logic       stop;
    logic [3:0] set_ones;
    logic [2:0] set_tens;
    logic [3:0] set_min;

    logic [3:0] a_dout1, b_dout1;
    logic [2:0] a_dout2, b_dout2;
    logic [3:0] a_dout3, b_dout3;
    logic       a_running, b_running;
    logic       a_done, b_done;
    logic       a_expired, b_expired;

    logic [13:0] obs_a;
    logic [13:0] obs_b;

    int checks = 0;
    int errors = 0;

    // Reference model: the remaining time as plain seconds, plus the number
    // of cycles already spent in the current second.
    typedef struct {
        int secs;
        int sub;
        bit run;
        bit dn;
        bit exp;
    } model_t;

    model_t mdl_a;
    model_t mdl_b;
    logic [13:0] q_a[$];
    logic [13:0] q_b[$];

    always #5 clk = ~clk;

    countdown_timer #(.TICK_DIV(1)) dut_a (
        .clk(clk), .reset(reset), .load(load), .start(start), .stop(stop),
        .set_ones(set_ones), .set_tens(set_tens), .set_min(set_min),
        .dout1(a_dout1), .dout2(a_dout2), .dout3(a_dout3),
        .running(a_running), .done(a_done), .expired(a_expired)
    );

    countdown_timer #(.TICK_DIV(4)) dut_b (
        .clk(clk), .reset(reset), .load(load), .start(start), .stop(stop),
        .set_ones(set_ones), .set_tens(set_tens), .set_min(set_min),
        .dout1(b_dout1), .dout2(b_dout2), .dout3(b_dout3),
        .running(b_running), .done(b_done), .expired(b_expired)
    );

    assign obs_a = {a_dout3, a_dout2, a_dout1, a_running, a_done, a_expired};
    assign obs_b = {b_dout3, b_dout2, b_dout1, b_running, b_done, b_expired};

    function automatic model_t reset_model();
        model_t m;
        m.secs = 0;
        m.sub  = 0;
        m.run  = 1'b0;
        m.dn   = 1'b0;
        m.exp  = 1'b0;
        return m;
    endfunction

    function automatic model_t step(model_t m, int div, bit ld, bit st, bit sp,
                                    int so, int stn, int sm);
        model_t n;
        n = m;
        n.exp = 1'b0;
        if (ld) begin
            n.secs = ((sm > 9) ? 9 : sm) * 60 + ((stn > 5) ? 5 : stn) * 10 + ((so > 9) ? 9 : so);
            n.sub  = 0;
            n.run  = 1'b0;
            n.dn   = 1'b0;
        end else if (m.run) begin
            n.sub = m.sub + 1;
            if (n.sub == div) begin
                n.sub  = 0;
                n.secs = m.secs - 1;
                if (n.secs == 0) begin
                    n.run = 1'b0;
                    n.dn  = 1'b1;
                    n.exp = 1'b1;
                end
            end
            if (n.run && sp) n.run = 1'b0;
        end else if (!m.dn && st && !sp && (m.secs != 0)) begin
            n.run = 1'b1;
        end
        return n;
    endfunction

    function automatic logic [13:0] expect_of(model_t m);
        return {4'(m.secs / 60), 3'((m.secs / 10) % 6), 4'(m.secs % 10), m.run, m.dn, m.exp};
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then queue the
    // model's prediction for the following rising edge.
    task automatic applyStimulus(bit ld, bit st, bit sp, logic [3:0] so,
                                 logic [2:0] stn, logic [3:0] sm);
        @(negedge clk);
        load     = ld;
        start    = st;
        stop     = sp;
        set_ones = so;
        set_tens = stn;
        set_min  = sm;
        if (!reset) begin
            mdl_a = reset_model();
            mdl_b = reset_model();
        end else begin
            mdl_a = step(mdl_a, 1, ld, st, sp, int'(so), int'(stn), int'(sm));
            mdl_b = step(mdl_b, 4, ld, st, sp, int'(so), int'(stn), int'(sm));
        end
        q_a.push_back(expect_of(mdl_a));
        q_b.push_back(expect_of(mdl_b));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 4'd0, 3'd0, 4'd0);
    endtask

    // Monitor: after each rising edge, compare the outputs against the
    // oldest queued prediction.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) checkOutput("div1_outputs", 32'(obs_a), 32'(q_a.pop_front()));
            if (q_b.size() > 0) checkOutput("div4_outputs", 32'(obs_b), 32'(q_b.pop_front()));
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        load     = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        set_ones = 4'd0;
        set_tens = 3'd0;
        set_min  = 4'd0;
        mdl_a    = reset_model();
        mdl_b    = reset_model();

        #2;
        checkOutput("reset_state_div1", 32'(obs_a), 32'd0);
        checkOutput("reset_state_div4", 32'(obs_b), 32'd0);
        #20;
        reset = 1'b1;

        $display("[TB] 0:12 countdown to expiry");
        applyStimulus(1, 0, 0, 4'd2, 3'd1, 4'd0);
        applyStimulus(0, 1, 0, 4'd0, 3'd0, 4'd0);
        idle(52);

        $display("[TB] 1:00 borrow across minutes");
        applyStimulus(1, 0, 0, 4'd0, 3'd0, 4'd1);
        applyStimulus(0, 1, 0, 4'd0, 3'd0, 4'd0);
        idle(14);

        $display("[TB] pause and resume inside a second");
        applyStimulus(1, 0, 0, 4'd5, 3'd0, 4'd0);
        applyStimulus(0, 1, 0, 4'd0, 3'd0, 4'd0);
        idle(5);
        applyStimulus(0, 0, 1, 4'd0, 3'd0, 4'd0);
        idle(3);
        applyStimulus(0, 1, 1, 4'd0, 3'd0, 4'd0);
        applyStimulus(0, 1, 0, 4'd0, 3'd0, 4'd0);
        idle(3);

        $display("[TB] clamped load and start at zero");
        applyStimulus(1, 0, 0, 4'd12, 3'd7, 4'd15);
        idle(2);
        applyStimulus(1, 0, 0, 4'd0, 3'd0, 4'd0);
        applyStimulus(0, 1, 0, 4'd0, 3'd0, 4'd0);
        idle(3);

        $display("[TB] commands in DONE and load during ticks");
        applyStimulus(1, 0, 0, 4'd3, 3'd0, 4'd0);
        applyStimulus(0, 1, 0, 4'd0, 3'd0, 4'd0);
        idle(14);
        applyStimulus(0, 1, 0, 4'd0, 3'd0, 4'd0);
        applyStimulus(0, 0, 1, 4'd0, 3'd0, 4'd0);
        applyStimulus(1, 0, 0, 4'd3, 3'd0, 4'd0);
        applyStimulus(0, 1, 0, 4'd0, 3'd0, 4'd0);
        idle(5);
        applyStimulus(1, 0, 0, 4'd7, 3'd0, 4'd0);
        idle(2);

        $display("[TB] asynchronous reset mid-run");
        applyStimulus(0, 1, 0, 4'd0, 3'd0, 4'd0);
        idle(2);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_div1", 32'(obs_a), 32'd0);
        checkOutput("async_reset_div4", 32'(obs_b), 32'd0);
        mdl_a = reset_model();
        mdl_b = reset_model();
        idle(2);
        @(posedge clk);
        #3;
        reset = 1'b1;
        idle(4);

        $display("[TB] randomized command stream");
        for (int i = 0; i < 3000; i++) begin
            bit         ld;
            bit         st;
            bit         sp;
            logic [3:0] so;
            logic [2:0] stn;
            logic [3:0] sm;
            ld  = ($urandom_range(0, 39) == 0);
            st  = ($urandom_range(0, 5) == 0);
            sp  = ($urandom_range(0, 11) == 0);
            so  = 4'($urandom_range(0, 15));
            stn = 3'($urandom_range(0, 7));
            sm  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            applyStimulus(ld, st, sp, so, stn, sm);
        end

        idle(1);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("queue_drain", 32'(q_a.size() + q_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
